// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Consumer-side controller for the main FIFO. It issues registered `read`
// pulses based on the FIFO occupancy count, captures the FIFO's registered
// output word two cycles after each read, and queues captured words in a
// 4-entry skid buffer. The buffer is presented downstream on a valid/ready
// handshake. The controller never reads an empty FIFO and never overflows its
// own buffer, and it sustains one word per cycle when downstream is ready.
//
// Parameters
//   DATA_SIZE   width of a FIFO data word
//   COUNT_SIZE  width of the FIFO occupancy count and of pop_count
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset_L     asynchronous active-low reset
//   enable      1 = new reads may be issued; in-flight reads always complete
//   fifo_empty  FIFO empty flag (sanity check only)
//   fifo_count  FIFO occupancy, updated on the edge that samples `read`
//   fifo_data   FIFO output word, valid the cycle after the FIFO samples read
//   fifo_error  FIFO error flag
//   ready_in    downstream accepts data_out this cycle
//   read        registered pop request to the FIFO
//   data_out    head of the skid buffer (0 while the buffer is empty)
//   valid_out   skid buffer non-empty
//   pop_count   words handed downstream, modulo 2^COUNT_SIZE
//   err         sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module fifo_reader #(
    parameter int DATA_SIZE  = 6,
    parameter int COUNT_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [COUNT_SIZE-1:0] fifo_count,
    input  logic [DATA_SIZE-1:0]  fifo_data,
    input  logic                  fifo_error,
    input  logic                  ready_in,
    output logic                  read,
    output logic [DATA_SIZE-1:0]  data_out,
    output logic                  valid_out,
    output logic [COUNT_SIZE-1:0] pop_count,
    output logic                  err
);

    localparam logic [COUNT_SIZE-1:0] CNT_ONE = {{(COUNT_SIZE-1){1'b0}}, 1'b1};

    logic                 rd_d1;
    logic                 empty_d1;
    logic [DATA_SIZE-1:0] mem [4];
    logic [1:0]           wr_ptr;
    logic [1:0]           rd_ptr;
    logic [2:0]           buf_cnt;

    logic [1:0]           pending;
    logic [3:0]           committed;
    logic                 pop;
    logic                 push;
    logic                 overflow;
    logic                 err_next;
    logic                 read_next;

    assign valid_out = (buf_cnt != 3'd0);
    // No bypass: the head is only visible once it sits in the buffer. Gating
    // with valid_out keeps the output at 0 after reset without resetting mem.
    assign data_out  = valid_out ? mem[rd_ptr] : '0;

    always_comb begin
        pending   = {1'b0, read} + {1'b0, rd_d1};
        pop       = valid_out && ready_in;
        // Slots already owned: stored words plus words still in flight, less
        // the word leaving on this edge. A new read is only issued when this
        // leaves room, so a capture can never land on a full buffer.
        committed = {1'b0, buf_cnt} + {2'b00, pending} - {3'b000, pop};
        // A capture into a full buffer is only legal if the head leaves on
        // the same edge; otherwise the word is dropped and err is raised.
        push      = rd_d1 && ((buf_cnt != 3'd4) || pop);
        overflow  = rd_d1 && (buf_cnt == 3'd4) && !pop;
        // empty_d1 holds fifo_empty as seen on the edge that sampled read,
        // so rd_d1 && empty_d1 means the FIFO was popped while empty.
        err_next  = err || fifo_error || overflow || (rd_d1 && empty_d1);
        // fifo_count lags read by one edge; comparing against the current
        // read keeps the last word from being popped twice.
        read_next = enable
                    && (fifo_count > {{(COUNT_SIZE-1){1'b0}}, read})
                    && (committed < 4'd4)
                    && !err;
    end

    // Read issue / capture / handshake control
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            read      <= 1'b0;
            rd_d1     <= 1'b0;
            empty_d1  <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            buf_cnt   <= 3'd0;
            pop_count <= '0;
            err       <= 1'b0;
        end else begin
            read     <= read_next;
            rd_d1    <= read;
            empty_d1 <= fifo_empty;
            err      <= err_next;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 2'd1;
                pop_count <= pop_count + CNT_ONE;
            end
            if (push && !pop) begin
                buf_cnt <= buf_cnt + 3'd1;
            end else if (pop && !push) begin
                buf_cnt <= buf_cnt - 3'd1;
            end
        end
    end

    // Skid buffer storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fifo_data;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
//
// Bench for fifo_reader. A small behavioural FIFO supplies words (registered
// count and data, updated on the edge that samples read). Expected downstream
// words are queued as each scenario is set up; a separate monitor pops and
// compares whenever a handshake completes. Directed scenario checks run in
// the stimulus process.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

    localparam int DATA_SIZE  = 6;
    localparam int COUNT_SIZE = 4;

    logic                  clk;
    logic                  reset_L;
    logic                  enable;
    logic                  fifo_empty;
    logic [COUNT_SIZE-1:0] fifo_count = '0;
    logic [DATA_SIZE-1:0]  fifo_data  = '0;
    logic                  fifo_error;
    logic                  ready_in;
    logic                  read;
    logic [DATA_SIZE-1:0]  data_out;
    logic                  valid_out;
    logic [COUNT_SIZE-1:0] pop_count;
    logic                  err;

    fifo_reader #(
        .DATA_SIZE  (DATA_SIZE),
        .COUNT_SIZE (COUNT_SIZE)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .fifo_data  (fifo_data),
        .fifo_error (fifo_error),
        .ready_in   (ready_in),
        .read       (read),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .pop_count  (pop_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: words are appended by the stimulus at negedges,
    // popped on the rising edge that samples read.
    logic [DATA_SIZE-1:0] fq [$];

    always @(posedge clk) begin
        if (read && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
        end
        fifo_count <= COUNT_SIZE'(fq.size());
    end

    assign fifo_empty = (fifo_count == '0);

    // Scoreboard monitor
    logic [DATA_SIZE-1:0]  exp_q [$];
    logic [DATA_SIZE-1:0]  mon_exp;
    logic [COUNT_SIZE-1:0] mon_pops = '0;
    int                    m_pass   = 0;
    int                    m_total  = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset_L) begin
                mon_pops = '0;
            end else if (valid_out && ready_in) begin
                m_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_word: got data %0d, no word expected", data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (data_out === mon_exp && pop_count === mon_pops) begin
                        m_pass++;
                    end else begin
                        $display("FAIL word: got data %0d pop_count %0d, required data %0d pop_count %0d",
                                 data_out, pop_count, mon_exp, mon_pops);
                    end
                end
                mon_pops = mon_pops + COUNT_SIZE'(1);
            end
        end
    end

    // Directed checks
    int c_pass  = 0;
    int c_total = 0;
    int n_rd, n_vl, n_dchg, rd_first, rd_last, vl_first;

    task automatic check(input string name, input int act, input int req);
        c_total++;
        if (act == req) c_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(DATA_SIZE'(first + i));
    endtask

    task automatic expect_words(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(DATA_SIZE'(first + i));
    endtask

    // Runs n cycles, sampling at each negedge: read/valid statistics and
    // changes of data_out while stalled.
    task automatic run_cycles(input int n);
        logic [DATA_SIZE-1:0] prev;
        bit                   prev_ok;
        n_rd = 0; n_vl = 0; n_dchg = 0;
        rd_first = -1; rd_last = -1; vl_first = -1;
        prev = '0; prev_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (read) begin
                n_rd++;
                if (rd_first < 0) rd_first = i;
                rd_last = i;
            end
            if (valid_out) begin
                n_vl++;
                if (vl_first < 0) vl_first = i;
            end
            if (valid_out && !ready_in) begin
                if (prev_ok && data_out != prev) n_dchg++;
                prev    = data_out;
                prev_ok = 1'b1;
            end else begin
                prev_ok = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        reset_L = 1'b0; enable = 1'b0; ready_in = 1'b0; fifo_error = 1'b0;
        #1;
        check("rst_read",      int'(read),      0);
        check("rst_valid",     int'(valid_out), 0);
        check("rst_data",      int'(data_out),  0);
        check("rst_pop_count", int'(pop_count), 0);
        check("rst_err",       int'(err),       0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;

        // Stream 3,4,5 with downstream ready
        ready_in = 1'b1; enable = 1'b1;
        load(3, 3); expect_words(3, 3);
        run_cycles(12);
        check("stream_reads",     n_rd, 3);
        check("stream_read_span", rd_last - rd_first + 1, 3);
        check("stream_valids",    n_vl, 3);
        check("stream_latency",   vl_first - rd_first, 2);
        check("stream_pop_count", int'(pop_count), 3);
        check("stream_err",       int'(err), 0);
        check("stream_drained",   exp_q.size(), 0);

        // Last word: count lag must not cause a second read
        load(7, 1); expect_words(7, 1);
        run_cycles(8);
        check("last_reads",     n_rd, 1);
        check("last_valids",    n_vl, 1);
        check("last_err",       int'(err), 0);
        check("last_pop_count", int'(pop_count), 4);
        check("last_drained",   exp_q.size(), 0);

        // Asynchronous reset with three words buffered
        ready_in = 1'b0;
        load(20, 4);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (dut.buf_cnt == 3'd3) hit = 1'b1;
        end
        check("mid_reached_buf3", int'(hit), 1);
        reset_L = 1'b0;
        #1;
        check("mid_rst_read",      int'(read),      0);
        check("mid_rst_valid",     int'(valid_out), 0);
        check("mid_rst_data",      int'(data_out),  0);
        check("mid_rst_pop_count", int'(pop_count), 0);
        check("mid_rst_err",       int'(err),       0);
        fq.delete();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        run_cycles(3);
        check("post_rst_reads",     n_rd, 0);
        check("post_rst_valids",    n_vl, 0);
        check("post_rst_pop_count", int'(pop_count), 0);

        // Backpressure: 8 words, downstream stalled
        ready_in = 1'b0;
        load(3, 8); expect_words(3, 8);
        run_cycles(12);
        check("bp_reads",   n_rd, 4);
        check("bp_buf_cnt", int'(dut.buf_cnt), 4);
        check("bp_valid",   int'(valid_out), 1);
        check("bp_data",    int'(data_out), 3);
        check("bp_stable",  n_dchg, 0);
        run_cycles(4);
        check("bp_hold_reads", n_rd, 0);
        check("bp_hold_data",  int'(data_out), 3);
        check("bp_err",        int'(err), 0);
        ready_in = 1'b1;
        run_cycles(30);
        check("bp_pop_count", int'(pop_count), 8);
        check("bp_drained",   exp_q.size(), 0);
        check("bp_err_after", int'(err), 0);

        // Enable dropped after the second read cycle: two words delivered
        enable = 1'b0; ready_in = 1'b1;
        load(30, 4); expect_words(30, 2);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("en_first_read", int'(read), 1);
        @(negedge clk);
        check("en_second_read", int'(read), 1);
        enable = 1'b0;
        run_cycles(10);
        check("en_later_reads", n_rd, 0);
        check("en_pop_count",   int'(pop_count), 10);
        check("en_drained",     exp_q.size(), 0);

        // Fill to 4, then a capture landing on the same edge as a pop
        ready_in = 1'b0;
        load(34, 4); expect_words(32, 6);
        enable = 1'b1;
        run_cycles(8);
        check("sim_reads",   n_rd, 4);
        check("sim_full",    int'(dut.buf_cnt), 4);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        check("sim_refill_read", int'(read), 1);
        check("sim_after_pop",   int'(dut.buf_cnt), 3);
        @(negedge clk);
        check("sim_in_flight",   int'(dut.buf_cnt), 3);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        check("sim_push_pop_cnt", int'(dut.buf_cnt), 3);
        check("sim_push_pop_err", int'(err), 0);
        run_cycles(4);
        check("sim_refull_reads", n_rd, 0);
        check("sim_refull",       int'(dut.buf_cnt), 4);
        check("sim_refull_err",   int'(err), 0);
        ready_in = 1'b1;
        run_cycles(12);
        check("sim_pop_count_wrap", int'(pop_count), 0);
        check("sim_drained",        exp_q.size(), 0);
        check("sim_valid_end",      int'(valid_out), 0);

        // FIFO error: sticky, blocks reads, buffer still drains
        ready_in = 1'b0;
        load(40, 6); expect_words(40, 4);
        run_cycles(10);
        check("err_fill_reads", n_rd, 4);
        check("err_fill_cnt",   int'(dut.buf_cnt), 4);
        fifo_error = 1'b1;
        @(negedge clk);
        fifo_error = 1'b0;
        check("err_set", int'(err), 1);
        ready_in = 1'b1;
        run_cycles(12);
        check("err_no_reads",  n_rd, 0);
        check("err_sticky",    int'(err), 1);
        check("err_drain_vld", int'(valid_out), 0);
        check("err_pop_count", int'(pop_count), 4);
        check("err_drained",   exp_q.size(), 0);
        reset_L = 1'b0;
        #1;
        check("err_cleared", int'(err), 0);
        fq.delete();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        check("err_clear_held", int'(err), 0);

        $display("%0d/%0d checks passed", c_pass + m_pass, c_total + m_total);
        $finish;
    end

endmodule
